// File: rtl/osd_scaled_overlay.sv
// Scaled on-screen-display overlay: tracks raster position, fetches upsampled overlay
// pixels from an external RAM and mixes them into the video stream with fixed 3-cycle latency.
module osd_scaled_overlay #(
    parameter int unsigned OSD_WIDTH  = 64,
    parameter int unsigned OSD_HEIGHT = 64,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned PIX_W      = 8
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_de,
    input  logic [23:0]      i_data,
    input  logic [11:0]      i_pos_x,
    input  logic [11:0]      i_pos_y,
    input  logic [1:0]       i_mode,
    input  logic             i_enable,
    output logic             o_ram_rd,
    output logic [15:0]      o_ram_addr,
    input  logic [PIX_W-1:0] i_ram_data,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic [23:0]      o_data,
    output logic             o_frame_start
);

    localparam int unsigned CW    = 12;
    localparam int unsigned AW    = 16;
    localparam int unsigned ROW_W = OSD_WIDTH >> SCALE_LOG2;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_REPLACE = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_KEY     = 2'd3
    } mode_e;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
    } vid_t;

    logic [CW-1:0] x_cnt, y_cnt;
    logic          de_d, vs_d;
    logic [CW-1:0] sh_pos_x, sh_pos_y;
    logic [1:0]    sh_mode;
    logic          sh_en;

    logic          vs_rise, de_fall;
    logic [CW-1:0] pos_x_e, pos_y_e, cur_y;
    logic [1:0]    mode_e_c;
    logic          en_e;
    logic [CW:0]   x_ext, y_ext, px_ext, py_ext;
    logic          in_x, in_y, hit_c;
    logic [CW-1:0] sx, sy;
    logic [AW-1:0] addr_c;

    vid_t          v1, v2;
    logic [1:0]    mode1, mode2;
    logic          hit2;
    logic [7:0]    d8;
    logic [23:0]   pix_c;

    // The pixel that coincides with a vsync rise belongs to the new frame: it sees y=0
    // and the freshly latched overlay controls.
    always_comb begin
        vs_rise  = i_vs & ~vs_d;
        de_fall  = ~i_de & de_d;
        pos_x_e  = vs_rise ? i_pos_x  : sh_pos_x;
        pos_y_e  = vs_rise ? i_pos_y  : sh_pos_y;
        mode_e_c = vs_rise ? i_mode   : sh_mode;
        en_e     = vs_rise ? i_enable : sh_en;
        cur_y    = vs_rise ? '0 : y_cnt;
    end

    // Region test in 13 bits so a region running past 4095 is clipped rather than wrapped.
    always_comb begin
        x_ext  = {1'b0, x_cnt};
        y_ext  = {1'b0, cur_y};
        px_ext = {1'b0, pos_x_e};
        py_ext = {1'b0, pos_y_e};
        in_x   = (x_ext >= px_ext) && (x_ext < px_ext + (CW+1)'(OSD_WIDTH));
        in_y   = (y_ext >= py_ext) && (y_ext < py_ext + (CW+1)'(OSD_HEIGHT));
        hit_c  = i_de & en_e & in_x & in_y;
        sx     = (x_cnt - pos_x_e) >> SCALE_LOG2;
        sy     = (cur_y - pos_y_e) >> SCALE_LOG2;
        addr_c = AW'(32'(sy) * ROW_W + 32'(sx));
    end

    // Raster position counters and per-frame shadow controls.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            sh_pos_x <= '0;
            sh_pos_y <= '0;
            sh_mode  <= '0;
            sh_en    <= 1'b0;
        end else begin
            de_d <= i_de;
            vs_d <= i_vs;
            if (i_de) begin
                x_cnt <= (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 12'd1;
            end else begin
                x_cnt <= '0;
            end
            if (vs_rise) begin
                y_cnt <= '0;
            end else if (de_fall && (y_cnt != CNT_MAX)) begin
                y_cnt <= y_cnt + 12'd1;
            end
            if (vs_rise) begin
                sh_pos_x <= i_pos_x;
                sh_pos_y <= i_pos_y;
                sh_mode  <= i_mode;
                sh_en    <= i_enable;
            end
        end
    end

    // Stage 1 issues the RAM read; stage 2 waits for the RAM's one-cycle read latency.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            o_ram_rd      <= 1'b0;
            o_ram_addr    <= '0;
            o_frame_start <= 1'b0;
            v1            <= '0;
            v2            <= '0;
            mode1         <= '0;
            mode2         <= '0;
            hit2          <= 1'b0;
        end else begin
            o_ram_rd      <= hit_c;
            o_frame_start <= vs_rise;
            if (hit_c) begin
                o_ram_addr <= addr_c;
            end
            v1    <= '{hs: i_hs, vs: i_vs, de: i_de, data: i_data};
            mode1 <= mode_e_c;
            v2    <= v1;
            mode2 <= mode1;
            hit2  <= o_ram_rd;
        end
    end

    generate
        if (PIX_W >= 8) begin : g_d_trunc
            assign d8 = i_ram_data[PIX_W-1 -: 8];
        end else begin : g_d_pad
            assign d8 = {i_ram_data, {(8-PIX_W){1'b0}}};
        end
    endgenerate

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'(a) + 9'(b);
        return s[8:1];
    endfunction

    // Overlay mixer; non-hit pixels always pass through untouched.
    always_comb begin
        pix_c = v2.data;
        if (hit2) begin
            unique case (mode_e'(mode2))
                MODE_REPLACE: pix_c = {d8, d8, d8};
                MODE_BLEND:   pix_c = {avg8(v2.data[23:16], d8),
                                       avg8(v2.data[15:8],  d8),
                                       avg8(v2.data[7:0],   d8)};
                MODE_KEY:     pix_c = (d8 != 8'd0) ? {d8, d8, d8} : v2.data;
                default:      pix_c = v2.data;
            endcase
        end
    end

    // Stage 3: registered video outputs.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            o_hs   <= v2.hs;
            o_vs   <= v2.vs;
            o_de   <= v2.de;
            o_data <= pix_c;
        end
    end

endmodule

// File: tb/tb_osd_scaled_overlay.sv
// Self-checking bench for osd_scaled_overlay: directed and randomized frames against a
// position/region reference model driven by the bench's own raster coordinates.
module tb_osd_scaled_overlay;

    localparam int OSD_W = 64;
    localparam int OSD_H = 64;
    localparam int SCL   = 1;
    localparam int SC    = 1 << SCL;
    localparam int PIX_W = 8;

    logic             pclk = 1'b0;
    logic             rst;
    logic             i_hs, i_vs, i_de, i_enable;
    logic [23:0]      i_data;
    logic [11:0]      i_pos_x, i_pos_y;
    logic [1:0]       i_mode;
    logic             o_ram_rd;
    logic [15:0]      o_ram_addr;
    logic [PIX_W-1:0] i_ram_data;
    logic             o_hs, o_vs, o_de, o_frame_start;
    logic [23:0]      o_data;

    osd_scaled_overlay #(
        .OSD_WIDTH(OSD_W), .OSD_HEIGHT(OSD_H), .SCALE_LOG2(SCL), .PIX_W(PIX_W)
    ) dut (
        .pclk(pclk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .i_pos_x(i_pos_x), .i_pos_y(i_pos_y), .i_mode(i_mode), .i_enable(i_enable),
        .o_ram_rd(o_ram_rd), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data), .o_frame_start(o_frame_start)
    );

    always #5 pclk = ~pclk;

    // Synchronous-read overlay RAM: content is a keyed function of the address.
    logic [7:0] ram_key = 8'd0;
    logic [7:0] ram_q   = 8'd0;

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        return a[7:0] ^ ram_key;
    endfunction

    always_ff @(posedge pclk) begin
        if (o_ram_rd) ram_q <= ram_val(o_ram_addr);
    end
    assign i_ram_data = ram_q;

    typedef struct {
        logic        hs, vs, de;
        logic [23:0] in_data;
        logic [23:0] out_data;
        bit          hit;
        logic [7:0]  d;
        logic [1:0]  mode;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          last_vs;
    int          sh_px, sh_py;
    logic [1:0]  sh_mode;
    bit          sh_en;
    logic [15:0] exp_addr;
    bit          lit_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [23:0] c, input logic [7:0] d,
                                            input logic [1:0] m, input bit hit);
        int r, g, b;
        if (!hit) return c;
        r = (int'(c[23:16]) + int'(d)) / 2;
        g = (int'(c[15:8])  + int'(d)) / 2;
        b = (int'(c[7:0])   + int'(d)) / 2;
        case (m)
            2'd1:    return {d, d, d};
            2'd2:    return {8'(r), 8'(g), 8'(b)};
            2'd3:    return (d != 8'd0) ? {d, d, d} : c;
            default: return c;
        endcase
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '{hs: 0, vs: 0, de: 0, in_data: 0, out_data: 0, hit: 0, d: 0, mode: 0};
        q.delete();
        q.push_back(z);
        q.push_back(z);
        last_vs  = 0;
        sh_px    = 0;
        sh_py    = 0;
        sh_mode  = 2'd0;
        sh_en    = 0;
        exp_addr = 16'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},    32'(o_ram_rd), 32'd0);
        chk({tag, "_addr"},  32'(o_ram_addr), 32'd0);
        chk({tag, "_fs"},    32'(o_frame_start), 32'd0);
        chk({tag, "_sync"},  {29'd0, o_hs, o_vs, o_de}, 32'd0);
        chk({tag, "_data"},  32'(o_data), 32'd0);
    endtask

    // One pixel clock: model the driven inputs at raster position (x,y), then check outputs.
    task automatic tick(input int x, input int y);
        exp_t e;
        bit   vs_rise, hit;
        int   addr;
        vs_rise = (i_vs === 1'b1) && !last_vs;
        last_vs = (i_vs === 1'b1);
        if (vs_rise) begin
            sh_px   = int'(i_pos_x);
            sh_py   = int'(i_pos_y);
            sh_mode = i_mode;
            sh_en   = i_enable;
        end
        hit = i_de && sh_en && x >= sh_px && x < sh_px + OSD_W && y >= sh_py && y < sh_py + OSD_H;
        if (hit) begin
            addr     = ((y - sh_py) / SC) * (OSD_W / SC) + (x - sh_px) / SC;
            exp_addr = 16'(addr);
        end
        e.hs = i_hs; e.vs = i_vs; e.de = i_de; e.in_data = i_data;
        e.hit = hit; e.d = ram_val(exp_addr); e.mode = sh_mode;
        e.out_data = exp_pix(i_data, e.d, sh_mode, hit);
        q.push_back(e);
        @(posedge pclk);
        #1;
        chk("ram_rd", 32'(o_ram_rd), 32'(hit));
        chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
        chk("frame_start", 32'(o_frame_start), 32'(vs_rise));
        e = q.pop_front();
        chk("sync", {29'd0, o_hs, o_vs, o_de}, {29'd0, e.hs, e.vs, e.de});
        chk("data", 32'(o_data), 32'(e.out_data));
        if (lit_en && e.hit && e.mode == 2'd2 && e.d == 8'h40 && e.in_data == 24'hFF8000)
            chk("blend_lit", 32'(o_data), 32'h009F6020);
        if (lit_en && e.hit && e.mode == 2'd3 && e.d == 8'h00)
            chk("key0_lit", 32'(o_data), 32'(e.in_data));
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge pclk);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_ctrl(input int px, input int py, input int m, input bit en);
        i_pos_x  = 12'(px);
        i_pos_y  = 12'(py);
        i_mode   = 2'(m);
        i_enable = en;
    endtask

    task automatic rand_ctrl();
        set_ctrl(int'($urandom_range(0, 90)), int'($urandom_range(0, 45)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    endtask

    task automatic run_frame(input int lines, input int pix, input bit fixed, input logic [23:0] fval,
                             input bit vs_on_de, input int chg_line, input int chg_x,
                             input int rst_line, input int rst_pix, input bit rnd_chg);
        if (!vs_on_de) begin
            for (int i = 0; i < 8; i++) begin
                i_vs = (i < 4); i_hs = 1'b0; i_de = 1'b0; i_data = 24'($urandom);
                tick(0, 0);
            end
        end
        for (int l = 0; l < lines; l++) begin
            if (l == chg_line) i_pos_x = 12'(chg_x);
            if (rnd_chg && $urandom_range(0, 3) == 0) rand_ctrl();
            for (int p = 0; p < pix; p++) begin
                if (l == rst_line && p == rst_pix) reset_pulse();
                i_vs   = vs_on_de && l == 0 && p < 4;
                i_hs   = 1'b0;
                i_de   = 1'b1;
                i_data = fixed ? fval : 24'($urandom);
                tick((p > 4095) ? 4095 : p, (l > 4095) ? 4095 : l);
            end
            for (int b = 0; b < 8; b++) begin
                i_vs = 1'b0; i_hs = (b < 3); i_de = 1'b0; i_data = 24'($urandom);
                tick(0, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = 24'd0;
        set_ctrl(0, 0, 0, 1'b0);
        repeat (3) @(posedge pclk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();

        // Disabled overlay, then enabled bypass mode
        set_ctrl(10, 2, 1, 1'b0);
        run_frame(20, 80, 0, 24'd0, 0, -1, 0, -1, -1, 0);
        set_ctrl(10, 2, 0, 1'b1);
        run_frame(20, 80, 0, 24'd0, 0, -1, 0, -1, -1, 0);

        // Replace mode at (650,2) with RAM data = address
        ram_key = 8'd0;
        set_ctrl(650, 2, 1, 1'b1);
        run_frame(8, 720, 0, 24'd0, 0, -1, 0, -1, -1, 0);

        // Mid-frame position change only takes effect next frame
        run_frame(8, 720, 0, 24'd0, 0, 3, 100, -1, -1, 0);
        run_frame(8, 720, 0, 24'd0, 0, -1, 0, -1, -1, 0);

        // Blend and colour-key literal cases
        lit_en = 1;
        set_ctrl(0, 0, 2, 1'b1);
        run_frame(8, 70, 1, 24'hFF8000, 0, -1, 0, -1, -1, 0);
        set_ctrl(0, 0, 3, 1'b1);
        run_frame(8, 70, 1, 24'h123456, 0, -1, 0, -1, -1, 0);
        lit_en = 0;

        // Region clipped at the right edge of the 12-bit coordinate space
        set_ctrl(4060, 0, 1, 1'b1);
        run_frame(2, 4096, 0, 24'd0, 0, -1, 0, -1, -1, 0);

        // vsync rise coinciding with an active pixel
        set_ctrl(0, 0, 1, 1'b1);
        run_frame(6, 40, 0, 24'd0, 1, -1, 0, -1, -1, 0);

        // Reset in the middle of the region, then recovery on the next frame
        set_ctrl(10, 2, 1, 1'b1);
        run_frame(20, 80, 0, 24'd0, 0, -1, 0, 5, 20, 0);
        run_frame(20, 80, 0, 24'd0, 0, -1, 0, -1, -1, 0);

        // Randomized frames with mid-frame control churn
        for (int f = 0; f < 6; f++) begin
            ram_key = 8'($urandom);
            rand_ctrl();
            run_frame(40, 80, 0, 24'd0, 0, -1, 0, -1, -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osd_scaled_overlay.md
OSD_SCALED_OVERLAY -- requirements
Module: osd_scaled_overlay

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- OSD_WIDTH, 64: overlay width in display pixels.
- OSD_HEIGHT, 64: overlay height in display pixels.
- SCALE_LOG2, 1: upsample factor 2^SCALE_LOG2 (legal values 0..2).
- PIX_W, 8: overlay RAM pixel width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- pclk, in, 1: pixel clock.
- rst, in, 1: reset.
- i_hs, in, 1: input horizontal sync.
- i_vs, in, 1: input vertical sync (active-high).
- i_de, in, 1: input data enable.
- i_data, in, 24: input RGB888 pixel.
- i_pos_x, in, 12: overlay left edge, in display pixels.
- i_pos_y, in, 12: overlay top edge, in display pixels.
- i_mode, in, 2: overlay mode.
- i_enable, in, 1: overlay enable.
- o_ram_rd, out, 1: overlay RAM read strobe.
- o_ram_addr, out, 16: overlay RAM read address.
- i_ram_data, in, PIX_W: overlay RAM read data.
- o_hs, out, 1: output horizontal sync.
- o_vs, out, 1: output vertical sync.
- o_de, out, 1: output data enable.
- o_data, out, 24: output RGB888 pixel.
- o_frame_start, out, 1: one-cycle pulse at frame start.

REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 Position counters (12-bit x, y):
- x counts i_de-high pixels within a line, starting at 0, and clears when i_de is low.
- y increments on each i_de falling edge and clears on each i_vs rising edge.
- Both counters saturate at 4095.

REQ-005 On each i_vs rising edge, the block latches i_pos_x, i_pos_y, i_mode and i_enable into shadow registers; all overlay decisions use the shadow values only, so mid-frame input changes take effect at the next frame.

REQ-006 o_frame_start pulses high for exactly one cycle, 1 cycle after the i_vs rising edge is sampled.

REQ-007 Region hit, for pixel (x, y):
- Condition: i_de=1, shadow enable=1, pos_x <= x < pos_x+OSD_WIDTH, and pos_y <= y < pos_y+OSD_HEIGHT.
- Comparisons use 13-bit sums, so the region is clipped, never wrapped, beyond 4095.

REQ-008 Address generation:
- sx = (x-pos_x)>>SCALE_LOG2; sy = (y-pos_y)>>SCALE_LOG2.
- o_ram_addr = sy*(OSD_WIDTH>>SCALE_LOG2)+sx, zero-extended to 16 bits.

REQ-009 RAM read timing:
- o_ram_rd and o_ram_addr are registered and valid 1 cycle after the pixel is sampled.
- o_ram_rd equals the region hit.
- o_ram_addr holds its last value when o_ram_rd=0.
- i_ram_data is sampled exactly 1 cycle after o_ram_rd.

REQ-010 o_hs, o_vs, o_de and o_data have a fixed latency of 3 pclk cycles from the i_* inputs, independent of mode or hit.

REQ-011 Pixel output, where d = i_ram_data upper 8 bits (zero-padded if PIX_W<8) and c = each 8-bit channel of the delayed i_data:
- Mode 0: bypass; o_data = delayed i_data.
- Mode 1: replace; o_data = {d,d,d} on hit.
- Mode 2: blend; each channel = (c+d)>>1 using 9-bit intermediate and truncation, on hit.
- Mode 3: colour key; as mode 1 if d!=0, else bypass.
- Any non-hit pixel: bypass.

REQ-012 A line or frame shorter than the region (i_de falls or i_vs rises early) terminates the hit immediately, with no stale reads.

REQ-013 Simultaneous i_vs rise and i_de=1: y clears first, and the pixel is treated as y=0.

Reset
REQ-014 While rst=1:
- All outputs are 0.
- Counters are 0.
- Shadow registers are 0, so the overlay is disabled.
- The pipeline is flushed.

REQ-015 After rst deasserts:
- The overlay remains disabled until the first i_vs rising edge latches the shadow registers.
- Pixels emerge with 3-cycle latency from the first post-reset input.

REQ-016 Reset asserted mid-line forces all outputs to 0 within the same cycle (asynchronous clear); there is no partial-frame recovery before the next i_vs.

Verification
REQ-017 Scenario: 800x600 frame, enable=1, mode=1, pos=(650,2), SCALE_LOG2=1, RAM data = address[7:0] -> at (650,2), addr=0; at (651,3), addr=0; at (652,4), addr=33; o_data = {addr[7:0] x3} at +3 cycles.

REQ-018 Scenario: mode=2, input pixel 0xFF8000, d=0x40 -> o_data = 0x9F6020; mode=3 with d=0 -> o_data = input unchanged.

REQ-019 Scenario: change i_pos_x from 650 to 100 at line 300 -> current frame keeps 650; next frame hits at x=100.

REQ-020 Scenario: pos_x=4060, OSD_WIDTH=64 -> hits only for x in 4060..4095; no hit at x=0..27 of the next line.

REQ-021 Scenario: rst pulsed mid-region -> outputs 0 at once; no o_ram_rd until the next i_vs rise.

REQ-022 Scenario: enable=0 or mode=0 for a full frame -> o_data/o_hs/o_vs/o_de equal the inputs delayed by 3 cycles; o_ram_rd stays 0 when enable=0.
